// File: rtl/axi4_postmortem_reader_if.sv
// axi4_postmortem_reader_if: AXI4 read address/data channels (40-bit address, 64-bit data)
interface axi4_postmortem_reader_if;
  logic [3:0]  M_AXI_ARID;
  logic [39:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARLOCK;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic [3:0]  M_AXI_ARQOS;
  logic [3:0]  M_AXI_ARREGION;
  logic [7:0]  M_AXI_ARUSER;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [3:0]  M_AXI_RID;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic [7:0]  M_AXI_RUSER;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  modport master (
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
           M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARREGION, M_AXI_ARUSER, M_AXI_ARVALID,
           M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID
  );
  modport slave (
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
           M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARREGION, M_AXI_ARUSER, M_AXI_ARVALID,
           M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID
  );
endinterface

// File: rtl/axi4_postmortem_reader.sv
// axi4_postmortem_reader: AXI4 read master streaming a postmortem record out of DDR in 4 KB-safe INCR bursts
module axi4_postmortem_reader #(
  parameter int BURST_LEN = 16,
  parameter int LEN_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [39:0]             i_ddr_addr,
  input  logic [LEN_W-1:0]        i_len,
  output logic [63:0]             o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [1:0]              o_state,
  axi4_postmortem_reader_if.master m_axi
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;
  state_t state, nstate;
  logic [39:0] cur_addr, araddr, nxt_addr, end_addr;
  logic [LEN_W-1:0] remaining, nxt_rem, rem_dec;
  logic [8:0] beat_cnt, b_cap, beats;
  logic [9:0] b_4k;
  logic [7:0] arlen;
  logic err, acc, last_beat, start, unused_ok;
  assign start = state == IDLE && i_start;
  assign acc = state == DATA && m_axi.M_AXI_RVALID && i_ready;
  assign last_beat = beat_cnt == {1'b0, arlen};
  assign rem_dec = remaining - LEN_W'(1);
  assign end_addr = cur_addr + ((40'(arlen) + 40'd1) << 3);
  // Next burst is sized from the values being loaded this cycle (start or burst end)
  assign nxt_addr = state == IDLE ? {i_ddr_addr[39:3], 3'b000} : end_addr;
  assign nxt_rem = state == IDLE ? i_len : rem_dec;
  assign b_cap = (32'(nxt_rem) < BURST_LEN) ? 9'(nxt_rem) : 9'(BURST_LEN);
  assign b_4k = 10'd512 - {1'b0, nxt_addr[11:3]};
  assign beats = ({1'b0, b_cap} < b_4k) ? b_cap : b_4k[8:0];
  assign unused_ok = ^{i_ddr_addr[2:0], m_axi.M_AXI_RID, m_axi.M_AXI_RUSER, m_axi.M_AXI_RRESP[0]};
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= IDLE;
    else state <= nstate;
  // Bursts end on the beat count; RLAST is only cross-checked for the error flag
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (i_start) nstate = i_len == '0 ? DONE : ADDR;
      ADDR: if (m_axi.M_AXI_ARREADY) nstate = DATA;
      DATA: if (acc && last_beat) nstate = rem_dec == '0 ? DONE : ADDR;
      DONE: nstate = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state != IDLE;
    o_done = state == DONE;
    o_state = state;
    o_err = err;
    o_data = m_axi.M_AXI_RDATA;
    o_valid = state == DATA && m_axi.M_AXI_RVALID;
    m_axi.M_AXI_RREADY = state == DATA && i_ready;
    m_axi.M_AXI_ARVALID = state == ADDR;
    m_axi.M_AXI_ARADDR = araddr;
    m_axi.M_AXI_ARLEN = arlen;
    m_axi.M_AXI_ARID = 4'd0;
    m_axi.M_AXI_ARSIZE = 3'b011;
    m_axi.M_AXI_ARBURST = 2'b01;
    m_axi.M_AXI_ARLOCK = 1'b0;
    m_axi.M_AXI_ARCACHE = 4'b0011;
    m_axi.M_AXI_ARPROT = 3'd0;
    m_axi.M_AXI_ARQOS = 4'd0;
    m_axi.M_AXI_ARREGION = 4'd0;
    m_axi.M_AXI_ARUSER = 8'd0;
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      cur_addr <= '0;
      remaining <= '0;
      beat_cnt <= '0;
      araddr <= '0;
      arlen <= '0;
      err <= 1'b0;
    end else begin
      if (start) begin
        cur_addr <= nxt_addr;
        remaining <= i_len;
      end
      if (acc) begin
        remaining <= rem_dec;
        beat_cnt <= last_beat ? 9'd0 : beat_cnt + 9'd1;
        if (last_beat) cur_addr <= end_addr;
      end
      if (nstate == ADDR && state != ADDR) begin
        araddr <= nxt_addr;
        arlen <= 8'(beats - 9'd1);
      end
      err <= start ? 1'b0 : err | (acc && (m_axi.M_AXI_RRESP[1] || (m_axi.M_AXI_RLAST != last_beat)));
    end
endmodule

// File: tb/tb_axi4_postmortem_reader.sv
// tb_axi4_postmortem_reader: random AXI slave plus queue-based burst/data model checked every cycle
module tb_axi4_postmortem_reader;
  localparam int BL = 16;
  localparam int LW = 16;
  logic clk = 0, rst_n = 1, i_start = 0, i_ready = 0;
  logic [39:0] i_ddr_addr = '0;
  logic [LW-1:0] i_len = '0;
  logic [63:0] o_data;
  logic o_valid, o_busy, o_done, o_err;
  logic [1:0] o_state;
  axi4_postmortem_reader_if axi();
  axi4_postmortem_reader #(.BURST_LEN(BL), .LEN_W(LW)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(i_start), .i_ddr_addr(i_ddr_addr), .i_len(i_len),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_state(o_state), .m_axi(axi)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, done_cnt = 0, gbeat = 0;
  logic [39:0] exp_ar_addr[$];
  logic [7:0] exp_ar_len[$];
  logic [63:0] exp_data[$];
  logic [63:0] seed = 64'h0123_4567_89AB_CDEF;
  bit exp_err = 0, rv_always = 0, inj_nolast = 0, inj_early = 0, first_done = 0;
  int ar_delay = 0, rdy_mode = 0, err_beat = -1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] word(input logic [39:0] a);
    return {a[31:0], ~a[31:0]} ^ seed;
  endfunction
  // Reference: split [addr, addr+8*len) into chunks of at most BL words not crossing 4 KB
  task automatic plan(input logic [39:0] addr, input int len);
    logic [39:0] a;
    int r, b;
    a = {addr[39:3], 3'b000};
    for (int i = 0; i < len; i++) exp_data.push_back(word(a + 40'(i) * 40'd8));
    r = len;
    while (r > 0) begin
      b = r < BL ? r : BL;
      if ((4096 - int'(a[11:0])) / 8 < b) b = (4096 - int'(a[11:0])) / 8;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(8'(b - 1));
      a += 40'(b) * 40'd8;
      r -= b;
    end
  endtask
  task automatic go(input logic [39:0] addr, input int len, input bit err);
    int d0;
    exp_err = err;
    gbeat = 0;
    first_done = 0;
    seed = {$urandom, $urandom};
    exp_data.delete();
    plan(addr, len);
    d0 = done_cnt;
    @(posedge clk); #1;
    i_ddr_addr = addr;
    i_len = LW'(len);
    i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
    @(negedge clk);
    chk("err_cleared_on_start", o_err, 0);
    if (len > 0) chk("ar_latency", axi.M_AXI_ARVALID, 1);
    else begin
      chk("len0_done", o_done, 1);
      chk("len0_no_arvalid", axi.M_AXI_ARVALID, 0);
    end
    for (int c = 0; c < 4000 && done_cnt == d0; c++) @(negedge clk);
    chk("done_seen", 64'(done_cnt - d0), 1);
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
  endtask
  // Slave: samples handshakes at negedge, drives new values just after posedge
  initial begin
    bit ar_hs, r_hs, arv, active;
    logic [39:0] cap_a, s_addr;
    logic [7:0] cap_l;
    int s_n, s_beat, ar_cnt;
    active = 0; s_n = 0; s_beat = 0; ar_cnt = 0; s_addr = '0;
    axi.M_AXI_ARREADY = 0; axi.M_AXI_RVALID = 0; axi.M_AXI_RDATA = '0; axi.M_AXI_RRESP = '0;
    axi.M_AXI_RLAST = 0; axi.M_AXI_RID = '0; axi.M_AXI_RUSER = '0;
    forever begin
      @(negedge clk);
      ar_hs = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
      r_hs = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
      arv = axi.M_AXI_ARVALID;
      cap_a = axi.M_AXI_ARADDR;
      cap_l = axi.M_AXI_ARLEN;
      @(posedge clk); #1;
      if (!rst_n) begin
        active = 0; ar_cnt = 0;
        axi.M_AXI_ARREADY = 0; axi.M_AXI_RVALID = 0; axi.M_AXI_RLAST = 0; axi.M_AXI_RRESP = '0;
      end else begin
        if (r_hs) begin
          s_beat++; gbeat++;
          if (s_beat == s_n) begin active = 0; first_done = 1; end
        end
        if (ar_hs) begin
          active = 1; s_addr = cap_a; s_n = int'(cap_l) + 1; s_beat = 0; ar_cnt = 0;
        end else if (arv) ar_cnt++;
        axi.M_AXI_ARREADY = ar_cnt >= ar_delay;
        if (!(axi.M_AXI_RVALID && !r_hs)) begin
          if (active && (rv_always || $urandom_range(0, 3) != 0)) begin
            axi.M_AXI_RVALID = 1;
            axi.M_AXI_RDATA = word(s_addr + 40'(s_beat) * 40'd8);
            axi.M_AXI_RRESP = gbeat == err_beat ? 2'b10 : 2'b00;
            axi.M_AXI_RLAST = s_beat == s_n - 1;
            if (inj_nolast && !first_done && s_beat == s_n - 1) axi.M_AXI_RLAST = 0;
            if (inj_early && !first_done && s_beat == 0 && s_n > 1) axi.M_AXI_RLAST = 1;
          end else begin
            axi.M_AXI_RVALID = 0; axi.M_AXI_RLAST = 0; axi.M_AXI_RRESP = '0;
          end
        end
      end
      i_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~i_ready : 1'($urandom_range(0, 1));
    end
  end
  // Compare process
  initial begin
    bit prev_arv, prev_hs, prev_done;
    logic [39:0] prev_a;
    logic [7:0] prev_l;
    int ar_cycles;
    prev_arv = 0; prev_hs = 0; prev_done = 0; ar_cycles = 0; prev_a = '0; prev_l = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_arv = 0; prev_hs = 0; prev_done = 0; ar_cycles = 0;
      end else begin
        if (prev_hs) chk("arvalid_drop", axi.M_AXI_ARVALID, 0);
        else if (prev_arv) begin
          chk("ar_hold_valid", axi.M_AXI_ARVALID, 1);
          chk("ar_hold_addr", axi.M_AXI_ARADDR, prev_a);
          chk("ar_hold_len", axi.M_AXI_ARLEN, prev_l);
        end
        if (axi.M_AXI_ARVALID) ar_cycles++;
        if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
          if (exp_ar_addr.size() == 0) chk("unexpected_ar", 1, 0);
          else begin
            chk("araddr", axi.M_AXI_ARADDR, exp_ar_addr.pop_front());
            chk("arlen", axi.M_AXI_ARLEN, exp_ar_len.pop_front());
            chk("ar_wait_cycles", 64'(ar_cycles), 64'(ar_delay + 1));
          end
          ar_cycles = 0;
        end
        chk("rready", axi.M_AXI_RREADY, o_state == 2'd2 ? i_ready : 1'b0);
        chk("o_valid", o_valid, o_state == 2'd2 ? axi.M_AXI_RVALID : 1'b0);
        if (o_valid && i_ready) begin
          if (exp_data.size() == 0) chk("unexpected_beat", 1, 0);
          else chk("o_data", o_data, exp_data.pop_front());
        end
        if (o_done) begin
          done_cnt++;
          chk("done_err", o_err, exp_err);
          chk("done_data_left", 64'(exp_data.size()), 0);
          chk("done_ar_left", 64'(exp_ar_addr.size()), 0);
          chk("done_one_cycle", prev_done, 0);
        end
        prev_arv = axi.M_AXI_ARVALID;
        prev_hs = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
        prev_done = o_done;
        prev_a = axi.M_AXI_ARADDR;
        prev_l = axi.M_AXI_ARLEN;
      end
    end
  end
  initial begin
    logic [39:0] ra;
    int rl;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_arvalid", axi.M_AXI_ARVALID, 0);
    chk("rst_araddr", axi.M_AXI_ARADDR, 0);
    chk("rst_arlen", axi.M_AXI_ARLEN, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    rst_n = 1;
    // Pin the model against hand-computed burst splits
    plan(40'h10000000, 40);
    chk("model_t1_a0", exp_ar_addr[0], 40'h10000000); chk("model_t1_l0", exp_ar_len[0], 15);
    chk("model_t1_a1", exp_ar_addr[1], 40'h10000080); chk("model_t1_l1", exp_ar_len[1], 15);
    chk("model_t1_a2", exp_ar_addr[2], 40'h10000100); chk("model_t1_l2", exp_ar_len[2], 7);
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
    plan(40'h00000FC0, 16);
    chk("model_t2_a0", exp_ar_addr[0], 40'h00000FC0); chk("model_t2_l0", exp_ar_len[0], 7);
    chk("model_t2_a1", exp_ar_addr[1], 40'h00001000); chk("model_t2_l1", exp_ar_len[1], 7);
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
    go(40'h10000000, 40, 0);
    go(40'h00000FC0, 16, 0);
    rv_always = 1; rdy_mode = 1;
    go(40'h20000000, 16, 0);
    rv_always = 0; rdy_mode = 0; ar_delay = 5;
    go(40'h30000008, 20, 0);
    ar_delay = 0; err_beat = 5;
    go(40'h40000000, 8, 1);
    err_beat = -1;
    go(40'h40000100, 8, 0);
    inj_nolast = 1;
    go(40'h50000000, 20, 1);
    inj_nolast = 0; inj_early = 1;
    go(40'h50001000, 10, 1);
    inj_early = 0;
    go(40'h60000000, 0, 0);
    for (int t = 0; t < 16; t++) begin
      ra = {8'($urandom), $urandom};
      if (t % 2 == 0) ra[11:0] = 12'hE00 | 12'($urandom_range(0, 511));
      rl = $urandom_range(0, 70);
      ar_delay = $urandom_range(0, 3);
      rdy_mode = 2;
      rv_always = 1'($urandom_range(0, 1));
      err_beat = (rl > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, rl - 1) : -1;
      go(ra, rl, err_beat >= 0);
    end
    err_beat = -1; ar_delay = 0; rdy_mode = 0;
    exp_err = 0;
    exp_data.delete();
    plan(40'h70000000, 40);
    @(posedge clk); #1;
    i_ddr_addr = 40'h70000000; i_len = 40; i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
    for (int c = 0; c < 200 && o_state != 2'd2; c++) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_state", o_state, 0);
    chk("midrst_arvalid", axi.M_AXI_ARVALID, 0);
    chk("midrst_rready", axi.M_AXI_RREADY, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_araddr", axi.M_AXI_ARADDR, 0);
    chk("midrst_arlen", axi.M_AXI_ARLEN, 0);
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    go(40'h80000000, 24, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
